// File: rtl/lisnoc_packet_arb_mux_pkg.sv
// Shared flit-type encoding and arbiter state for the lisnoc packet arbiter/mux.
package lisnoc_packet_arb_mux_pkg;

  // Flit type lives in the MSBs of every flit.
  typedef enum logic [1:0] {
    FLIT_PAYLOAD = 2'b00,
    FLIT_HEAD    = 2'b01,
    FLIT_LAST    = 2'b10,
    FLIT_SINGLE  = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // A winner in IDLE keeps the grant when its flit does not end the packet.
  function automatic logic flit_opens_packet(input flit_type_e t);
    return (t == FLIT_HEAD) || (t == FLIT_PAYLOAD);
  endfunction

  // SINGLE is treated as terminating so a stray SINGLE cannot wedge the lock.
  function automatic logic flit_closes_packet(input flit_type_e t);
    return (t == FLIT_LAST) || (t == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/lisnoc_packet_arb_mux_arb_prio_rr.sv
// Round-robin arbiter: the next grant is the first requester after the last grant,
// wrapping around. With no request the last grant is returned unchanged.
module lisnoc_arb_prio_rr
  import lisnoc_packet_arb_mux_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] gnt,
  output logic [N-1:0] nxt_gnt
);

  logic found;

  // Scan positions 1..N after the current one-hot grant and take the first request.
  always_comb begin
    nxt_gnt = gnt;
    found   = 1'b0;
    for (int off = 1; off <= N; off++) begin
      for (int i = 0; i < N; i++) begin
        if (gnt[i] && !found && req[(i + off) % N]) begin
          nxt_gnt               = '0;
          nxt_gnt[(i + off) % N] = 1'b1;
          found                 = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lisnoc_packet_arb_mux.sv
// N:1 wormhole output stage: round-robin arbitration, grant locked for a whole
// packet, one-entry registered output buffer.
module lisnoc_packet_arb_mux
  import lisnoc_packet_arb_mux_pkg::*;
#(
  parameter int N               = 2,
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [N*(flit_data_width+flit_type_width)-1:0]    in_flit,
  input  logic [N-1:0]                                      in_valid,
  output logic [N-1:0]                                      in_ready,
  output logic [flit_data_width+flit_type_width-1:0]        out_flit,
  output logic                                              out_valid,
  input  logic                                              out_ready
);

  localparam int FW = flit_data_width + flit_type_width;
  // Last grant at the top port so port 0 has first priority after reset.
  localparam logic [N-1:0] GNT_RST = {1'b1, {(N-1){1'b0}}};

  arb_state_e                  state_q, state_d;
  logic [N-1:0]                gnt_q, gnt_d;
  logic [N-1:0]                nxt_gnt, sel;
  logic                        out_valid_q, out_valid_d;
  logic [FW-1:0]               out_flit_q, out_flit_d;
  logic [FW-1:0]               sel_flit;
  logic [flit_type_width-1:0]  type_bits;
  flit_type_e                  cur_type;
  logic                        space, transfer;

  lisnoc_arb_prio_rr #(.N(N)) u_arb (
    .req     (in_valid),
    .gnt     (gnt_q),
    .nxt_gnt (nxt_gnt)
  );

  assign space    = !out_valid_q | out_ready;
  assign sel      = (state_q == ST_IDLE) ? nxt_gnt : gnt_q;
  assign in_ready = rst ? '0 : (sel & {N{space}});
  assign transfer = |(in_valid & in_ready);

  // One-hot AND-OR mux of the selected input flit.
  always_comb begin
    sel_flit = '0;
    for (int i = 0; i < N; i++) begin
      sel_flit |= in_flit[i*FW +: FW] & {FW{sel[i]}};
    end
  end

  assign type_bits = sel_flit[FW-1 -: flit_type_width];
  assign cur_type  = flit_type_e'(type_bits[flit_type_width-1 -: 2]);

  // Next-state for grant lock, round-robin pointer and output buffer.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    out_valid_d = out_valid_q;
    out_flit_d  = out_flit_q;
    if (transfer) begin
      out_flit_d  = sel_flit;
      out_valid_d = 1'b1;
      if (state_q == ST_IDLE) begin
        gnt_d = nxt_gnt;
        if (flit_opens_packet(cur_type)) state_d = ST_LOCKED;
      end else if (flit_closes_packet(cur_type)) begin
        state_d = ST_IDLE;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; a buffered flit is dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= GNT_RST;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
    end
  end

  assign out_flit  = out_flit_q;
  assign out_valid = out_valid_q;

  // A packet must open with HEAD; a PAYLOAD winner in IDLE is still forwarded.
  assert property (@(posedge clk) disable iff (rst)
    !((state_q == ST_IDLE) && transfer && (cur_type == FLIT_PAYLOAD)))
    else $error("lisnoc_packet_arb_mux: PAYLOAD flit opened a packet while idle");

endmodule

// File: tb/tb_lisnoc_packet_arb_mux.sv
// Bench for lisnoc_packet_arb_mux (N=4): per-port flit queues feed the DUT, a
// packet-level model predicts the grant and output buffer every cycle.
module tb_lisnoc_packet_arb_mux;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 2;
  localparam int FW = DW + TW;

  localparam logic [1:0] T_P = 2'b00;
  localparam logic [1:0] T_H = 2'b01;
  localparam logic [1:0] T_L = 2'b10;
  localparam logic [1:0] T_S = 2'b11;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*FW-1:0] in_flit;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [FW-1:0]   out_flit;
  logic            out_valid;
  logic            out_ready;

  always #5 clk = ~clk;

  lisnoc_packet_arb_mux #(.N(N), .flit_data_width(DW), .flit_type_width(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [FW-1:0] q [N][$];
  logic [FW-1:0] out_log [$];
  logic [N-1:0]  last_rdy;
  logic          last_ov;

  int            m_last;
  int            m_owner;
  logic          m_ov;
  logic [FW-1:0] m_of;

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int port, input int seq);
    return {t, 4'(port), 28'(seq)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input logic [FW-1:0] exp);
    logic [FW-1:0] a;
    a = (idx < out_log.size()) ? out_log[idx] : 'x;
    chk(name, 64'(a), 64'(exp));
  endtask

  task automatic chk_log_port(input string name, input int idx, input int port);
    logic [3:0] a;
    a = (idx < out_log.size()) ? out_log[idx][31:28] : 4'hx;
    chk(name, 64'(a), 64'(port));
  endtask

  task automatic model_reset();
    m_last  = N - 1;
    m_owner = -1;
    m_ov    = 1'b0;
    m_of    = '0;
  endtask

  // One clock: drive at negedge, compare #1 later, advance the model at posedge.
  task automatic step(input logic [N-1:0] ven, input logic ordy, input logic r);
    logic [N-1:0]  v;
    logic [N-1:0]  exp_rdy;
    logic [FW-1:0] f;
    int            take;
    logic          space;
    v       = '0;
    in_flit = '0;
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        in_flit[i*FW +: FW] = q[i][0];
        v[i] = ven[i];
      end
    end
    in_valid  = v;
    out_ready = ordy;
    rst       = r;
    #1;
    take  = -1;
    space = !m_ov || ordy;
    if (!r && space) begin
      if (m_owner >= 0) begin
        if (v[m_owner]) take = m_owner;
      end else begin
        for (int off = 1; off <= N; off++) begin
          int p;
          p = (m_last + off) % N;
          if (take < 0 && v[p]) take = p;
        end
      end
    end
    exp_rdy = '0;
    if (take >= 0) exp_rdy[take] = 1'b1;
    chk("in_ready", 64'(in_ready & v), 64'(exp_rdy));
    if (!space || r) chk("in_ready_blocked", 64'(in_ready), 64'(0));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("out_flit", 64'(out_flit), 64'(m_of));
    last_rdy = in_ready;
    last_ov  = out_valid;
    if (out_valid && ordy && !r) out_log.push_back(out_flit);
    @(posedge clk);
    if (r) begin
      model_reset();
      for (int i = 0; i < N; i++) q[i].delete();
    end else if (take >= 0) begin
      f    = q[take].pop_front();
      m_ov = 1'b1;
      m_of = f;
      if (m_owner < 0) begin
        m_last = take;
        if (f[FW-1 -: 2] == T_H || f[FW-1 -: 2] == T_P) m_owner = take;
      end else if (f[FW-1 -: 2] == T_L || f[FW-1 -: 2] == T_S) begin
        m_owner = -1;
      end
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    step('0, 1'b1, 1'b1);
    out_log.delete();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_flit   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();

    // 1: SINGLE flits on ports 1 and 3 alternate, port 1 first.
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      q[1].push_back(mk(T_S, 1, k));
      q[3].push_back(mk(T_S, 3, k));
    end
    step(4'b1010, 1'b1, 1'b0);
    chk("t1_in_ready_c0", 64'(last_rdy), 64'(4'b0010));
    repeat (3) step(4'b1010, 1'b1, 1'b0);
    chk_log("t1_out0", 0, mk(T_S, 1, 1));
    chk_log("t1_out1", 1, mk(T_S, 3, 1));
    chk_log("t1_out2", 2, mk(T_S, 1, 2));

    // 2: port0 packet locks out port2 until LAST; no output bubble.
    do_reset();
    q[0].push_back(mk(T_H, 0, 1));
    q[0].push_back(mk(T_P, 0, 2));
    q[0].push_back(mk(T_L, 0, 3));
    q[2].push_back(mk(T_S, 2, 1));
    for (int c = 0; c < 3; c++) begin
      step(4'b0101, 1'b1, 1'b0);
      chk("t2_in_ready_locked", 64'(last_rdy), 64'(4'b0001));
    end
    repeat (2) step(4'b0101, 1'b1, 1'b0);
    chk("t2_log_len", 64'(out_log.size()), 64'(4));
    chk_log("t2_out0", 0, mk(T_H, 0, 1));
    chk_log("t2_out1", 1, mk(T_P, 0, 2));
    chk_log("t2_out2", 2, mk(T_L, 0, 3));
    chk_log("t2_out3", 3, mk(T_S, 2, 1));

    // 3: downstream stall mid-packet freezes everything.
    do_reset();
    q[0].push_back(mk(T_H, 0, 1));
    q[0].push_back(mk(T_P, 0, 2));
    q[0].push_back(mk(T_P, 0, 3));
    q[0].push_back(mk(T_L, 0, 4));
    q[1].push_back(mk(T_S, 1, 1));
    step(4'b0011, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(4'b0011, 1'b0, 1'b0);
      chk("t3_in_ready_stall", 64'(last_rdy), 64'(0));
      chk("t3_out_held", 64'(out_flit), 64'(mk(T_H, 0, 1)));
    end
    repeat (5) step(4'b0011, 1'b1, 1'b0);
    chk_log("t3_out0", 0, mk(T_H, 0, 1));
    chk_log("t3_out1", 1, mk(T_P, 0, 2));
    chk_log("t3_out2", 2, mk(T_P, 0, 3));
    chk_log("t3_out3", 3, mk(T_L, 0, 4));
    chk_log("t3_out4", 4, mk(T_S, 1, 1));

    // 4: all four busy with SINGLE flits -> 0,1,2,3,0,1.
    do_reset();
    for (int p = 0; p < N; p++) begin
      q[p].push_back(mk(T_S, p, 1));
      q[p].push_back(mk(T_S, p, 2));
    end
    repeat (7) step(4'b1111, 1'b1, 1'b0);
    chk_log_port("t4_g0", 0, 0);
    chk_log_port("t4_g1", 1, 1);
    chk_log_port("t4_g2", 2, 2);
    chk_log_port("t4_g3", 3, 3);
    chk_log_port("t4_g4", 4, 0);
    chk_log_port("t4_g5", 5, 1);

    // 5: reset after port1 HEAD drops the buffer and restarts at port 0.
    do_reset();
    q[1].push_back(mk(T_H, 1, 1));
    q[1].push_back(mk(T_P, 1, 2));
    q[1].push_back(mk(T_L, 1, 3));
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b1);
    out_log.delete();
    for (int p = 0; p < N; p++) q[p].push_back(mk(T_S, p, 7));
    step(4'b1111, 1'b1, 1'b0);
    chk("t5_out_valid_after_rst", 64'(last_ov), 64'(0));
    chk("t5_first_grant", 64'(last_rdy), 64'(4'b0001));
    step(4'b1111, 1'b1, 1'b0);
    chk_log_port("t5_out0", 0, 0);

    // 6: idle cycles keep the grant pointer on port 2.
    do_reset();
    q[2].push_back(mk(T_S, 2, 1));
    step(4'b0100, 1'b1, 1'b0);
    repeat (3) step(4'b0000, 1'b1, 1'b0);
    q[0].push_back(mk(T_S, 0, 2));
    q[2].push_back(mk(T_S, 2, 3));
    step(4'b0101, 1'b1, 1'b0);
    chk("t6_wrap_grant", 64'(last_rdy), 64'(4'b0001));
    repeat (2) step(4'b0101, 1'b1, 1'b0);
    chk_log_port("t6_out0", 0, 2);
    chk_log_port("t6_out1", 1, 0);
    chk_log_port("t6_out2", 2, 2);

    // Random packets, valid gaps, back-pressure and occasional reset.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] ven;
      logic         ordy;
      logic         r;
      for (int p = 0; p < N; p++) begin
        if (q[p].size() == 0 && $urandom_range(0, 3) == 0) begin
          int len;
          len = int'($urandom_range(0, 3));
          if (len == 0) begin
            q[p].push_back(mk(T_S, p, int'($urandom_range(0, 32'h0FFF_FFFF))));
          end else begin
            q[p].push_back(mk(T_H, p, int'($urandom_range(0, 32'h0FFF_FFFF))));
            for (int k = 1; k < len; k++)
              q[p].push_back(mk(T_P, p, int'($urandom_range(0, 32'h0FFF_FFFF))));
            q[p].push_back(mk(T_L, p, int'($urandom_range(0, 32'h0FFF_FFFF))));
          end
        end
        ven[p] = ($urandom_range(0, 9) < 8);
      end
      ordy = ($urandom_range(0, 9) < 7);
      r    = ($urandom_range(0, 399) == 0);
      step(ven, ordy, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
